// File: rtl/glitch_seq_ctrl.sv
// Sequencer and hazard detector for the four-input glitch datapath.
// Optional macro GLITCH_SEQ_CNT_EN builds the saturating oGlitchCnt accumulator.
module glitch_seq_ctrl #(
   parameter int unsigned HOLD_CYC = 8,
   parameter int unsigned WIN_CYC  = 8,
   parameter int unsigned EW       = 3
) (
   input  logic          iClk,
   input  logic          iRst_n,
   input  logic          iVecValid,
   output logic          oVecReady,
   input  logic [3:0]    iVecFrom,
   input  logic [3:0]    iVecTo,
   output logic          oA,
   output logic          oB,
   output logic          oC,
   output logic          oD,
   input  logic          iG,
   output logic          oResValid,
   input  logic          iResReady,
   output logic [EW-1:0] oEdges,
   output logic          oGlitch,
   output logic [7:0]    oGlitchCnt,
   output logic          oBusy
);

   localparam int unsigned MaxCyc = (HOLD_CYC > WIN_CYC) ? HOLD_CYC : WIN_CYC;
   localparam int unsigned CW     = $clog2(MaxCyc) + 1;
   localparam logic [CW-1:0] HoldLd  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] WinLd   = CW'(WIN_CYC - 1);
   localparam logic [EW-1:0] EdgeMax = '1;

   typedef enum logic [1:0] {StIdle, StApplyFrom, StApplyTo, StReport} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    to_q, to_d;
   logic [3:0]    drv_q, drv_d;
   logic [EW-1:0] edge_cnt_q, edge_cnt_d;
   logic [EW-1:0] edges_q, edges_d;
   logic          glitch_q, glitch_d;
   logic          res_valid_q, res_valid_d;
   logic          s1_q, s2_q, s3_q;

   logic          edge_det;
   logic [EW-1:0] edge_nxt;
   logic          glitch_nxt;
   logic          win_done;

   // iG is asynchronous: two flops to resolve metastability, a third to see the edge
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= iG;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign edge_det   = s2_q ^ s3_q;
   assign edge_nxt   = (edge_det && (edge_cnt_q != EdgeMax)) ? edge_cnt_q + EW'(1) : edge_cnt_q;
   assign glitch_nxt = 32'(edge_nxt) >= 32'd2;
   assign win_done   = (state_q == StApplyTo) && (cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      to_d        = to_q;
      drv_d       = drv_q;
      edge_cnt_d  = edge_cnt_q;
      edges_d     = edges_q;
      glitch_d    = glitch_q;
      res_valid_d = res_valid_q;

      case (state_q)
         StIdle: begin
            if (iVecValid) begin
               to_d    = iVecTo;
               drv_d   = iVecFrom;
               cnt_d   = HoldLd;
               state_d = StApplyFrom;
            end
         end
         StApplyFrom: begin
            if (cnt_q == '0) begin
               drv_d      = to_q;
               edge_cnt_d = '0;
               cnt_d      = WinLd;
               state_d    = StApplyTo;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         StApplyTo: begin
            edge_cnt_d = edge_nxt;
            if (cnt_q == '0) begin
               edges_d     = edge_nxt;
               glitch_d    = glitch_nxt;
               res_valid_d = 1'b1;
               state_d     = StReport;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         StReport: begin
            if (iResReady) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         to_q        <= '0;
         drv_q       <= '0;
         edge_cnt_q  <= '0;
         edges_q     <= '0;
         glitch_q    <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         to_q        <= to_d;
         drv_q       <= drv_d;
         edge_cnt_q  <= edge_cnt_d;
         edges_q     <= edges_d;
         glitch_q    <= glitch_d;
         res_valid_q <= res_valid_d;
      end
   end

`ifdef GLITCH_SEQ_CNT_EN
   logic [7:0] gcnt_q, gcnt_d;

   always_comb begin
      gcnt_d = gcnt_q;
      if (win_done && glitch_nxt && (gcnt_q != 8'hFF)) begin
         gcnt_d = gcnt_q + 8'd1;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         gcnt_q <= '0;
      end else begin
         gcnt_q <= gcnt_d;
      end
   end

   assign oGlitchCnt = gcnt_q;
`else
   logic unused_win_done;
   assign unused_win_done = win_done;
   assign oGlitchCnt      = 8'd0;
`endif

   assign {oA, oB, oC, oD} = drv_q;
   assign oVecReady        = (state_q == StIdle);
   assign oBusy            = (state_q != StIdle);
   assign oResValid        = res_valid_q;
   assign oEdges           = edges_q;
   assign oGlitch          = glitch_q;

endmodule

// File: tb/tb_glitch_seq_ctrl.sv
// Scoreboard bench for glitch_seq_ctrl: directed transitions with hand-computed edge counts.
module tb_glitch_seq_ctrl;

   localparam int unsigned HOLD = 8;
   localparam int unsigned WIN  = 16;
   localparam int unsigned EW   = 3;

   logic          iClk = 1'b0;
   logic          iRst_n = 1'b0;
   logic          iVecValid = 1'b0;
   logic          oVecReady;
   logic [3:0]    iVecFrom = '0;
   logic [3:0]    iVecTo = '0;
   logic          oA, oB, oC, oD;
   logic          iG = 1'b0;
   logic          oResValid;
   logic          iResReady = 1'b1;
   logic [EW-1:0] oEdges;
   logic          oGlitch;
   logic [7:0]    oGlitchCnt;
   logic          oBusy;

   glitch_seq_ctrl #(
      .HOLD_CYC (HOLD),
      .WIN_CYC  (WIN),
      .EW       (EW)
   ) dut (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iVecValid  (iVecValid),
      .oVecReady  (oVecReady),
      .iVecFrom   (iVecFrom),
      .iVecTo     (iVecTo),
      .oA         (oA),
      .oB         (oB),
      .oC         (oC),
      .oD         (oD),
      .iG         (iG),
      .oResValid  (oResValid),
      .iResReady  (iResReady),
      .oEdges     (oEdges),
      .oGlitch    (oGlitch),
      .oGlitchCnt (oGlitchCnt),
      .oBusy      (oBusy)
   );

   always #5 iClk = ~iClk;

   typedef struct packed {
      logic [EW-1:0] edges;
      logic          glitch;
      logic [7:0]    gcnt;
   } res_t;

   res_t exp_q[$];
   res_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;
   int   exp_gcnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_expect(input int edges);
      res_t r;
      r.edges  = EW'(edges);
      r.glitch = (edges >= 2);
`ifdef GLITCH_SEQ_CNT_EN
      if (r.glitch && exp_gcnt < 255) exp_gcnt++;
`endif
      r.gcnt = 8'(exp_gcnt);
      exp_q.push_back(r);
   endtask

   // Result monitor: pops one expectation per result handshake
   always @(negedge iClk) begin
      if (iRst_n && oResValid && iResReady) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got edges=%0d expected no result", oEdges);
         end else begin
            mon_e = exp_q.pop_front();
            chk("res_edges", 32'(oEdges), 32'(mon_e.edges));
            chk("res_glitch", 32'(oGlitch), 32'(mon_e.glitch));
            chk("res_gcnt", 32'(oGlitchCnt), 32'(mon_e.gcnt));
         end
      end
   end

   // w[c] is applied to iG 1ns after the c-th edge following acceptance
   task automatic do_txn(input logic [3:0] vf, input logic [3:0] vt, input logic [63:0] w,
                         input int exp_edges, input bit bp);
      int lat;
      lat = 0;
      push_expect(exp_edges);
      iResReady = !bp;
      iVecFrom  = vf;
      iVecTo    = vt;
      iVecValid = 1'b1;
      @(posedge iClk);
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(posedge iClk);
         #1;
         if (c == 0) begin
            if (bp) begin
               iVecFrom = 4'hF;
               iVecTo   = 4'h0;
            end else begin
               iVecValid = 1'b0;
            end
         end
         iG = w[c];
         if (lat == 0 && oResValid) lat = c + 1;
         if (c == 3) begin
            chk("drive_from", 32'({oA, oB, oC, oD}), 32'(vf));
            chk("busy_ready", 32'({oBusy, oVecReady}), 32'b10);
         end
         if (c == HOLD + 2) chk("drive_to", 32'({oA, oB, oC, oD}), 32'(vt));
         if (bp && c >= HOLD + WIN && c <= HOLD + WIN + 4) begin
            chk("bp_valid", 32'(oResValid), 32'd1);
            chk("bp_edges", 32'(oEdges), 32'(exp_edges));
            chk("bp_glitch", 32'(oGlitch), 32'd1);
            chk("bp_ready", 32'(oVecReady), 32'd0);
            chk("bp_drive", 32'({oA, oB, oC, oD}), 32'(vt));
         end
         if (bp && c == HOLD + WIN + 4) begin
            iResReady = 1'b1;
            iVecValid = 1'b0;
         end
         if (bp && c == HOLD + WIN + 5) begin
            chk("bp_drop", 32'(oResValid), 32'd0);
            chk("bp_idle", 32'(oVecReady), 32'd1);
         end
      end
      chk("latency", 32'(lat), 32'(HOLD + WIN + 1));
      iResReady = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [63:0] w_clean, w_static, w_mask, w_sat;
      w_clean  = 64'hFFFF_FFFF_FFFF_FC00;
      w_static = ~64'h0000_0000_0000_0C00;
      w_mask   = ~64'h0000_0000_0000_000A;
      for (int c = 0; c < 64; c++) begin
         w_sat[c] = (c < 4) ? 1'b1 : (c > 31) ? 1'b1 : (((c - 4) / 2) % 2 == 1);
      end

      repeat (2) @(posedge iClk);
      #1 iRst_n = 1'b1;
      repeat (3) @(posedge iClk);
      #1;
      chk("rst_ready", 32'(oVecReady), 32'd1);
      chk("rst_busy", 32'(oBusy), 32'd0);
      chk("rst_drive", 32'({oA, oB, oC, oD}), 32'd0);
      chk("rst_resvalid", 32'(oResValid), 32'd0);
      chk("rst_edges", 32'(oEdges), 32'd0);
      chk("rst_gcnt", 32'(oGlitchCnt), 32'd0);

      do_txn(4'b0000, 4'b1000, w_clean, 1, 1'b0);
      do_txn(4'b1000, 4'b0010, w_static, 2, 1'b0);
      do_txn(4'b0100, 4'b0100, w_mask, 0, 1'b0);
      do_txn(4'b0011, 4'b1100, w_sat, 7, 1'b1);

      // Reset in the middle of the observation window
      iVecFrom  = 4'b1111;
      iVecTo    = 4'b0101;
      iVecValid = 1'b1;
      @(posedge iClk);
      #1 iVecValid = 1'b0;
      repeat (HOLD + 4) @(posedge iClk);
      #1;
      chk("mid_busy", 32'(oBusy), 32'd1);
      chk("mid_drive", 32'({oA, oB, oC, oD}), 32'b0101);
      iRst_n = 1'b0;
      #1;
      chk("mrst_ready", 32'(oVecReady), 32'd1);
      chk("mrst_busy", 32'(oBusy), 32'd0);
      chk("mrst_drive", 32'({oA, oB, oC, oD}), 32'd0);
      chk("mrst_resvalid", 32'(oResValid), 32'd0);
      chk("mrst_edges", 32'(oEdges), 32'd0);
      chk("mrst_glitch", 32'(oGlitch), 32'd0);
      chk("mrst_gcnt", 32'(oGlitchCnt), 32'd0);
      exp_gcnt = 0;
      @(posedge iClk);
      #1 iRst_n = 1'b1;
      repeat (2) @(posedge iClk);
      #1;

      do_txn(4'b1000, 4'b0010, w_static, 2, 1'b0);

      repeat (3) @(posedge iClk);
      #1;
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
